// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch widths, pc increment and fetch FSM state encoding
package cpu_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 64'd4;
  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD, HOLD} fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register (flush_i > hold_i > load_i > bubble); outputs valid_o, instr_o, pc_o
module ifid_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);
  logic               valid_q, valid_d, take;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  always_comb begin
    take    = !flush_i && !hold_i && load_i;
    valid_d = flush_i ? 1'b0 : hold_i ? valid_q : load_i;
    instr_d = take ? instr_i : instr_q;
    pc_d    = take ? pc_i : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch FSM; stall/redirect in, imem_req/imem_addr out, imem_ack/imem_rdata in, ifid_* out
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc
);
  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, tgt_q, tgt_d;
  logic [INSTR_W-1:0] hold_q, hold_d, load_instr;
  logic               load;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    hold_d     = hold_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    imem_req   = 1'b0;
    case (state_q)
      ISSUE: begin
        if (redirect) pc_d = redirect_pc;
        else if (!stall) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = stall && !redirect ? HOLD : ISSUE;
          if (redirect) pc_d = redirect_pc;
          else if (stall) hold_d = imem_rdata;
          else begin
            load = 1'b1;
            pc_d = pc_q + PC_INC;
          end
        end else if (redirect) begin
          tgt_d   = redirect_pc;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = ISSUE;
        end else if (redirect) tgt_d = redirect_pc;
      end
      HOLD: begin
        if (redirect) begin
          hold_d  = '0;
          pc_d    = redirect_pc;
          state_d = ISSUE;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_q + PC_INC;
          state_d    = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
    if (reset) imem_req = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end
  assign imem_addr = pc_q;
  ifid_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .hold_i  (stall),
    .load_i  (load),
    .instr_i (load_instr),
    .pc_i    (pc_q),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a transaction-level fetch model
module tb_fetch_stage;
  localparam logic [63:0] RST_PC = 64'h0;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ifid_valid;
  logic [63:0] imem_addr, ifid_pc;
  logic [31:0] ifid_instr;
  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  typedef struct {
    logic [63:0] addr;
    bit          acked;
    bit          killed;
  } ent_t;
  ent_t        pend[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [63:0] m_pc = '0, m_next = RST_PC;
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a == 64'h8 ? 32'h91000421 : (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction
  function automatic logic [63:0] rnd_pc();
    return $urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bit   exp_req;
    ent_t e;
    chk("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_valid});
    chk("ifid_instr", {32'd0, ifid_instr}, {32'd0, m_instr});
    chk("ifid_pc", ifid_pc, m_pc);
    exp_req = !reset && pend.size() == 0 && !stall && !redirect;
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (imem_req && exp_req) chk("imem_addr", imem_addr, m_next);
    if (reset) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_pc    = '0;
      m_next  = RST_PC;
      pend.delete();
    end else begin
      if (pend.size() != 0) begin
        e = pend[0];
        if (imem_ack) e.acked = 1'b1;
        if (redirect) e.killed = 1'b1;
        pend[0] = e;
      end
      if (redirect) begin
        m_valid = 1'b0;
        m_next  = redirect_pc;
      end else if (!stall) begin
        if (pend.size() != 0 && pend[0].acked && !pend[0].killed) begin
          m_valid = 1'b1;
          m_pc    = pend[0].addr;
          m_instr = mem_word(m_pc);
          void'(pend.pop_front());
        end else m_valid = 1'b0;
      end
      if (pend.size() != 0 && pend[0].acked && pend[0].killed) void'(pend.pop_front());
      if (exp_req) begin
        e = '{addr: m_next, acked: 1'b0, killed: 1'b0};
        pend.push_back(e);
        m_next = m_next + 64'd4;
      end
    end
  end
  int          lat_cnt = 0, lat_mode = 1;
  logic [63:0] lat_addr = '0, last_addr = '0;
  bit          spur_en = 1'b0, abandon = 1'b0, last_req = 1'b0;
  task automatic step(input bit st, input bit rd, input logic [63:0] rpc, input bit rs);
    @(posedge clk);
    #1;
    if (rs && abandon) lat_cnt = 0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      imem_ack   = lat_cnt == 0;
      imem_rdata = imem_ack ? mem_word(lat_addr) : $urandom;
    end else begin
      imem_ack   = spur_en && $urandom_range(0, 5) == 0;
      imem_rdata = $urandom;
    end
    reset       = rs;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    last_req  = imem_req && !reset;
    last_addr = imem_addr;
    if (last_req) begin
      lat_cnt  = lat_mode != 0 ? lat_mode : $urandom_range(1, 3);
      lat_addr = imem_addr;
    end
  endtask
  task automatic wait_req(input string name, input bit match, input logic [63:0] addr);
    int n = 0;
    do begin
      step(0, 0, '0, 0);
      n++;
    end while (!(last_req && (!match || last_addr == addr)) && n < 20);
    if (!(last_req && (!match || last_addr == addr))) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual_addr=%h required=%h", name, last_addr, addr);
    end
  endtask
  initial begin
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    chk("first_req_after_reset", {63'd0, last_req}, 64'd1);
    chk("first_req_addr", last_addr, RST_PC);
    wait_req("req_addr8", 1, 64'h8);
    repeat (4) step(1, 0, '0, 0);
    repeat (6) step(0, 0, '0, 0);
    lat_mode = 3;
    wait_req("req_redirect40", 0, '0);
    step(0, 1, 64'h40, 0);
    repeat (8) step(0, 0, '0, 0);
    wait_req("req_discard_overwrite", 0, '0);
    step(0, 1, 64'h100, 0);
    step(0, 1, 64'h200, 0);
    repeat (8) step(0, 0, '0, 0);
    lat_mode = 1;
    wait_req("req_redirect80", 0, '0);
    step(1, 1, 64'h80, 0);
    repeat (6) step(0, 0, '0, 0);
    wait_req("req_hold_redirect", 0, '0);
    step(1, 0, '0, 0);
    step(1, 1, 64'h300, 0);
    repeat (6) step(0, 0, '0, 0);
    wait_req("req_wrap", 0, '0);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    repeat (8) step(0, 0, '0, 0);
    lat_mode = 2;
    wait_req("req_reset_mid_wait", 0, '0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    repeat (6) step(0, 0, '0, 0);
    lat_mode = 0;
    spur_en  = 1'b1;
    abandon  = 1'b1;
    repeat (3000)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rnd_pc(), $urandom_range(0, 199) == 0);
    repeat (6) step(0, 0, '0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 Ports: clk  in  1  single clock, all state updates on posedge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: stall  in  1  hazard hold from decode; IF/ID must not advance.
REQ-005 Ports: redirect  in  1  branch taken or unconditional branch resolved downstream; flush and retarget.
REQ-006 Ports: redirect_pc  in  64  branch target, valid when redirect=1.
REQ-007 Ports: imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-008 Ports: imem_addr  out  64  fetch address, valid when imem_req=1.
REQ-009 Ports: imem_ack  in  1  response strobe, ≥1 cycle after imem_req.
REQ-010 Ports: imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 Ports: ifid_valid  out  1  IF/ID register holds a real instruction.
REQ-012 Ports: ifid_instr  out  32  IF/ID instruction to decode.
REQ-013 Ports: ifid_pc  out  64  PC of ifid_instr, for branch target arithmetic.

Function
REQ-014 FSM states: ISSUE, WAIT, DISCARD, HOLD; exactly one request outstanding at most.
REQ-015 ISSUE: if redirect, pc<=redirect_pc, imem_req=0, stay ISSUE; else if stall, imem_req=0, stay; else imem_req=1, imem_addr=pc, go WAIT.
REQ-016 WAIT, no ack: if redirect, latch redirect_pc into target register, go DISCARD; else stay.
REQ-017 WAIT, ack and redirect same cycle: discard imem_rdata, pc<=redirect_pc, go ISSUE.
REQ-018 WAIT, ack, no redirect, stall=1: imem_rdata into hold register, go HOLD.
REQ-019 WAIT, ack, no redirect, stall=0: IF/ID<={1, imem_rdata, pc}, pc<=pc+4, go ISSUE.
REQ-020 DISCARD: on ack discard data, pc<=latched target, go ISSUE; a later redirect before ack overwrites latched target.
REQ-021 HOLD: if redirect, drop hold, pc<=redirect_pc, go ISSUE; else if stall=0, IF/ID<={1, hold, pc}, pc<=pc+4, go ISSUE; else stay.
REQ-022 IF/ID priority per cycle: redirect (ifid_valid<=0) > stall (all IF/ID fields hold) > new instruction loaded > bubble (ifid_valid<=0, instr/pc hold).
REQ-023 imem_ack in ISSUE or HOLD is ignored.
REQ-024 pc increment wraps modulo 2^64; redirect_pc used unmodified.
REQ-025 Peak throughput: one instruction per 2 cycles at ack latency 1.

Reset
REQ-026 On reset: pc<=RESET_PC, state<=ISSUE, ifid_valid<=0, ifid_instr<=0, ifid_pc<=0, hold and target registers<=0.
REQ-027 During reset imem_req=0; reset overrides all other inputs.
REQ-028 Reset mid-WAIT/DISCARD abandons the request; its late ack is ignored per REQ-023.

Structure
REQ-029 Shared package cpu_pkg holds: PC width 64, instruction width 32, PC increment 4, fetch state enum.
REQ-030 One sub-module ifid_reg implements the IF/ID register with flush/hold/load/bubble priority of REQ-022.

Verification
REQ-031 Reset held 1 cycle, released, stall=0, ack latency 1 -> first imem_req with addr 0x0 in first cycle after release; ifid_pc sequence 0x0, 0x4, 0x8, valid on alternate cycles.
REQ-032 stall=1 asserted in WAIT, ack with 0x91000421 at addr 0x8 -> IF/ID unchanged, stays HOLD; cycle after stall=0 gives ifid_instr=0x91000421, ifid_pc=0x8.
REQ-033 redirect to 0x40 in WAIT (ack latency 3) -> ifid_valid=0 next cycle, acked data never reaches IF/ID, next imem_addr=0x40.
REQ-034 redirect to 0x80 in same cycle as ack -> data discarded, next imem_addr=0x80; redirect with stall=1 still clears ifid_valid.
REQ-035 Reset asserted in WAIT, ack arrives 1 cycle after release -> ignored, new request addr RESET_PC, ifid_valid=0 throughout.
REQ-036 pc=0xFFFFFFFFFFFFFFFC fetched -> next imem_addr=0x0.
